// File: rtl/i2c_register_target.sv
// I2C target with 7-bit address match, register pointer, byte writes and
// auto-incrementing burst reads against an external byte-wide register file.
module i2c_register_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h68,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       reg_re,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev, scl_s, sda_s;
  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   start_cond, stop_cond;
  logic [3:0]             bit_cnt, bit_cnt_n;
  logic [7:0]             rx_shift, rx_shift_n, tx_shift, tx_shift_n, rx_byte;
  logic [7:0]             reg_addr_n, reg_wdata_n;
  logic                   sda_oe_n, reg_we_n, reg_re_n, busy_n;
  logic                   master_ack, master_ack_n;

  // Synchronizers preset to the idle-bus level so reset never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev;
  assign scl_fall   = ~scl_s & scl_prev;
  assign sda_rise   = sda_s & ~sda_prev;
  assign sda_fall   = ~sda_s & sda_prev;
  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;
  assign rx_byte    = {rx_shift[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      sda_oe     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      busy       <= 1'b0;
      master_ack <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      rx_shift   <= rx_shift_n;
      tx_shift   <= tx_shift_n;
      sda_oe     <= sda_oe_n;
      reg_addr   <= reg_addr_n;
      reg_wdata  <= reg_wdata_n;
      reg_we     <= reg_we_n;
      reg_re     <= reg_re_n;
      busy       <= busy_n;
      master_ack <= master_ack_n;
    end
  end

  // Bus conditions take priority; otherwise the state acts on SCL edges only
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    rx_shift_n   = rx_shift;
    tx_shift_n   = tx_shift;
    sda_oe_n     = sda_oe;
    reg_addr_n   = reg_addr;
    reg_wdata_n  = reg_wdata;
    reg_we_n     = 1'b0;
    reg_re_n     = 1'b0;
    busy_n       = busy;
    master_ack_n = master_ack;

    if (start_cond) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (stop_cond) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR, PTR, WDATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            rx_shift_n = rx_byte;
            bit_cnt_n  = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (state == ADDR && rx_byte[7:1] != DEV_ADDR) state_n = IDLE;
              if (state == PTR) reg_addr_n = rx_byte;
              if (state == WDATA) begin
                reg_wdata_n = rx_byte;
                reg_we_n    = 1'b1;
              end
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n = 1'b1;
            case (state)
              ADDR: begin
                busy_n  = 1'b1;
                state_n = ADDR_ACK;
              end
              PTR:     state_n = PTR_ACK;
              default: state_n = WDATA_ACK;
            endcase
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = '0;
            if (!rx_shift[0]) begin
              sda_oe_n = 1'b0;
              state_n  = PTR;
            end else begin
              tx_shift_n = reg_rdata;
              sda_oe_n   = ~reg_rdata[7];
              reg_re_n   = 1'b1;
              state_n    = RDATA;
            end
          end
        end
        PTR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            state_n   = WDATA;
          end
        end
        WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n   = 1'b0;
            bit_cnt_n  = '0;
            reg_addr_n = reg_addr + 8'd1;
            state_n    = WDATA;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd7) begin
              sda_oe_n     = 1'b0;
              reg_addr_n   = reg_addr + 8'd1;
              master_ack_n = 1'b0;
              state_n      = RDATA_ACK;
            end else begin
              tx_shift_n = {tx_shift[6:0], 1'b0};
              sda_oe_n   = ~tx_shift[6];
              bit_cnt_n  = bit_cnt + 4'd1;
            end
          end
        end
        RDATA_ACK: begin
          // The master's ACK is seen on the rise; the next byte starts on the fall
          if (scl_rise) begin
            if (!sda_s) master_ack_n = 1'b1;
            else        state_n      = IDLE;
          end else if (scl_fall && master_ack) begin
            master_ack_n = 1'b0;
            tx_shift_n   = reg_rdata;
            sda_oe_n     = ~reg_rdata[7];
            reg_re_n     = 1'b1;
            bit_cnt_n    = '0;
            state_n      = RDATA;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
